cgra_route_tracer: RTL and testbench

- Read-back counterpart to the CGRA edge router, which writes per-PE routing bits into the config memory.
- Takes one (src, dst) edge request and walks the routed path through the PE config memory, one hop at a time.
- Streams each traversed hop out and ends with one status/hop-count result.
- Used after routing to verify placement and to drive the configuration serializer and debug dump.

---
 rtl/cgra_route_tracer.sv | 229 ++++++++++++++++++++++
 tb/tb_cgra_route_tracer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_route_tracer.sv
`default_nettype none
// ============================================================================
// Module   : cgra_route_tracer
// Purpose  : Reads back a routed CGRA edge from the PE config memory. It walks
//            from src toward dst one hop at a time (X first, then Y), streams
//            every traversed hop, and ends with one status / hop-count result.
// Ports    : clk, reset (sync, active-low)
//            req_valid/req_ready/req_src/req_dst    edge request
//            cfg_rd_en/cfg_addr/cfg_rdata           config memory read port
//                                                   (rdata one cycle after en)
//            hop_valid/hop_ready/hop_pe/hop_dir     hop record stream
//            res_valid/res_ready/res_status/res_hops final result
// Option   : TRACER_BYPASS_CHECK_EN - when defined, an intermediate PE whose
//            bypass count exceeds MAX_BYPASS ends the walk with OVERBYPASS.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_route_tracer #(
    parameter int GRID       = 4,
    parameter int PE_AW      = 4,
    parameter int MAX_HOPS   = 6,
    parameter int MAX_BYPASS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PE_AW-1:0] req_src,
    input  logic [PE_AW-1:0] req_dst,
    output logic             cfg_rd_en,
    output logic [PE_AW-1:0] cfg_addr,
    input  logic [5:0]       cfg_rdata,
    output logic             hop_valid,
    input  logic             hop_ready,
    output logic [PE_AW-1:0] hop_pe,
    output logic [1:0]       hop_dir,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_status,
    output logic [3:0]       res_hops
);

    localparam logic [PE_AW-1:0] c_GRID_W       = PE_AW'(GRID);
    localparam logic [3:0]       c_MAX_HOPS_W   = 4'(MAX_HOPS);
    localparam logic [1:0]       c_MAX_BYPASS_W = 2'(MAX_BYPASS);

    localparam logic [1:0] c_DIR_RIGHT = 2'd3;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_TOP   = 2'd1;
    localparam logic [1:0] c_DIR_BOT   = 2'd0;

    localparam logic [1:0] c_ST_OK         = 2'd0;
    localparam logic [1:0] c_ST_BROKEN     = 2'd1;
    localparam logic [1:0] c_ST_HOP_LIMIT  = 2'd2;
    localparam logic [1:0] c_ST_OVERBYPASS = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EVAL = 3'd2,
        S_HOP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state,      w_state_n;
    logic [PE_AW-1:0] r_cur,        w_cur_n;
    logic [PE_AW-1:0] r_dst,        w_dst_n;
    logic [3:0]       r_hops,       w_hops_n;
    logic [PE_AW-1:0] r_hop_pe,     w_hop_pe_n;
    logic [1:0]       r_hop_dir,    w_hop_dir_n;
    logic [1:0]       r_res_status, w_res_status_n;
    logic [3:0]       r_res_hops,   w_res_hops_n;

    // Grid coordinates of the current and destination PE
    logic [PE_AW-1:0] w_cur_col, w_cur_row, w_dst_col, w_dst_row;
    assign w_cur_col = r_cur % c_GRID_W;
    assign w_cur_row = r_cur / c_GRID_W;
    assign w_dst_col = r_dst % c_GRID_W;
    assign w_dst_row = r_dst / c_GRID_W;

    // X-first direction toward dst; only meaningful while cur != dst
    logic [1:0] w_dir;
    always_comb begin
        w_dir = c_DIR_TOP;
        if (w_cur_col < w_dst_col)      w_dir = c_DIR_RIGHT;
        else if (w_cur_col > w_dst_col) w_dir = c_DIR_LEFT;
        else if (w_cur_row < w_dst_row) w_dir = c_DIR_BOT;
        else                            w_dir = c_DIR_TOP;
    end

    // Direction bits are ordered so the direction code indexes them directly
    logic [3:0] w_dir_bits;
    assign w_dir_bits = cfg_rdata[3:0];

    // Neighbour reached by the pending hop; moves toward dst never wrap
    logic [PE_AW-1:0] w_next_pe;
    always_comb begin
        w_next_pe = r_cur;
        case (r_hop_dir)
            c_DIR_RIGHT: w_next_pe = r_cur + {{(PE_AW-1){1'b0}}, 1'b1};
            c_DIR_LEFT:  w_next_pe = r_cur - {{(PE_AW-1){1'b0}}, 1'b1};
            c_DIR_BOT:   w_next_pe = r_cur + c_GRID_W;
            default:     w_next_pe = r_cur - c_GRID_W;
        endcase
    end

    logic [3:0] w_hops_inc;
    assign w_hops_inc = r_hops + 4'd1;

    logic w_overbypass;
`ifdef TRACER_BYPASS_CHECK_EN
    // The source PE legitimately originates the edge, so it is exempt
    logic [PE_AW-1:0] r_src;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_src <= '0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_src <= req_src;
        end
    end
    assign w_overbypass = (r_cur != r_src) && (cfg_rdata[5:4] > c_MAX_BYPASS_W);
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{cfg_rdata[5:4], c_MAX_BYPASS_W};
    assign w_overbypass    = 1'b0;
`endif

    always_comb begin
        w_state_n      = r_state;
        w_cur_n        = r_cur;
        w_dst_n        = r_dst;
        w_hops_n       = r_hops;
        w_hop_pe_n     = r_hop_pe;
        w_hop_dir_n    = r_hop_dir;
        w_res_status_n = r_res_status;
        w_res_hops_n   = r_res_hops;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_cur_n  = req_src;
                    w_dst_n  = req_dst;
                    w_hops_n = 4'd0;
                    if (req_src == req_dst) begin
                        w_state_n      = S_DONE;
                        w_res_status_n = c_ST_OK;
                        w_res_hops_n   = 4'd0;
                    end else begin
                        w_state_n = S_READ;
                    end
                end
            end
            S_READ: begin
                w_state_n = S_EVAL;
            end
            S_EVAL: begin
                if (w_overbypass) begin
                    w_state_n      = S_DONE;
                    w_res_status_n = c_ST_OVERBYPASS;
                    w_res_hops_n   = r_hops;
                end else if (!w_dir_bits[w_dir]) begin
                    w_state_n      = S_DONE;
                    w_res_status_n = c_ST_BROKEN;
                    w_res_hops_n   = r_hops;
                end else begin
                    w_hop_pe_n  = r_cur;
                    w_hop_dir_n = w_dir;
                    w_state_n   = S_HOP;
                end
            end
            S_HOP: begin
                if (hop_ready) begin
                    w_cur_n  = w_next_pe;
                    w_hops_n = w_hops_inc;
                    if (w_next_pe == r_dst) begin
                        w_state_n      = S_DONE;
                        w_res_status_n = c_ST_OK;
                        w_res_hops_n   = w_hops_inc;
                    end else if (w_hops_inc == c_MAX_HOPS_W) begin
                        w_state_n      = S_DONE;
                        w_res_status_n = c_ST_HOP_LIMIT;
                        w_res_hops_n   = w_hops_inc;
                    end else begin
                        w_state_n = S_READ;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cur        <= '0;
            r_dst        <= '0;
            r_hops       <= '0;
            r_hop_pe     <= '0;
            r_hop_dir    <= '0;
            r_res_status <= '0;
            r_res_hops   <= '0;
        end else begin
            r_state      <= w_state_n;
            r_cur        <= w_cur_n;
            r_dst        <= w_dst_n;
            r_hops       <= w_hops_n;
            r_hop_pe     <= w_hop_pe_n;
            r_hop_dir    <= w_hop_dir_n;
            r_res_status <= w_res_status_n;
            r_res_hops   <= w_res_hops_n;
        end
    end

    // Handshake outputs are gated by reset so they drop as soon as it asserts
    assign req_ready  = reset && (r_state == S_IDLE);
    assign cfg_rd_en  = reset && (r_state == S_READ);
    assign hop_valid  = reset && (r_state == S_HOP);
    assign res_valid  = reset && (r_state == S_DONE);
    assign cfg_addr   = r_cur;
    assign hop_pe     = r_hop_pe;
    assign hop_dir    = r_hop_dir;
    assign res_status = r_res_status;
    assign res_hops   = r_res_hops;

endmodule
`default_nettype wire

// File: tb/tb_cgra_route_tracer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgra_route_tracer
// Purpose  : Self-checking bench for cgra_route_tracer. A behavioural path
//            model computes the expected hops, config reads and result for
//            directed and randomised walks. A second instance with a hop
//            limit of one exercises HOP_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgra_route_tracer;

    localparam int GRID       = 4;
    localparam int PE_AW      = 4;
    localparam int MAX_HOPS   = 6;
    localparam int MAX_BYPASS = 2;
    localparam int LIM_HOPS   = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic             req_valid = 1'b0, req_ready;
    logic [PE_AW-1:0] req_src = '0, req_dst = '0;
    logic             cfg_rd_en;
    logic [PE_AW-1:0] cfg_addr;
    logic [5:0]       cfg_rdata;
    logic             hop_valid, hop_ready = 1'b1;
    logic [PE_AW-1:0] hop_pe;
    logic [1:0]       hop_dir;
    logic             res_valid, res_ready = 1'b1;
    logic [1:0]       res_status;
    logic [3:0]       res_hops;

    logic             l_req_valid = 1'b0, l_req_ready;
    logic [PE_AW-1:0] l_req_src = '0, l_req_dst = '0;
    logic             l_cfg_rd_en;
    logic [PE_AW-1:0] l_cfg_addr;
    logic [5:0]       l_cfg_rdata;
    logic             l_hop_valid, l_hop_ready = 1'b1;
    logic [PE_AW-1:0] l_hop_pe;
    logic [1:0]       l_hop_dir;
    logic             l_res_valid, l_res_ready = 1'b1;
    logic [1:0]       l_res_status;
    logic [3:0]       l_res_hops;

    logic [5:0] mem [GRID*GRID];

    always @(posedge clk) begin
        cfg_rdata   <= mem[cfg_addr];
        l_cfg_rdata <= mem[l_cfg_addr];
    end

    cgra_route_tracer #(.GRID(GRID), .PE_AW(PE_AW), .MAX_HOPS(MAX_HOPS), .MAX_BYPASS(MAX_BYPASS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_dst(req_dst),
        .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr), .cfg_rdata(cfg_rdata),
        .hop_valid(hop_valid), .hop_ready(hop_ready), .hop_pe(hop_pe), .hop_dir(hop_dir),
        .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status), .res_hops(res_hops)
    );

    cgra_route_tracer #(.GRID(GRID), .PE_AW(PE_AW), .MAX_HOPS(LIM_HOPS), .MAX_BYPASS(MAX_BYPASS)) dut_lim (
        .clk(clk), .reset(reset),
        .req_valid(l_req_valid), .req_ready(l_req_ready), .req_src(l_req_src), .req_dst(l_req_dst),
        .cfg_rd_en(l_cfg_rd_en), .cfg_addr(l_cfg_addr), .cfg_rdata(l_cfg_rdata),
        .hop_valid(l_hop_valid), .hop_ready(l_hop_ready), .hop_pe(l_hop_pe), .hop_dir(l_hop_dir),
        .res_valid(l_res_valid), .res_ready(l_res_ready), .res_status(l_res_status), .res_hops(l_res_hops)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Expected walk, derived from grid coordinates and the memory contents
    int exp_pe[$];
    int exp_dir[$];
    int exp_rd[$];
    int exp_status;
    int exp_hops;

    task automatic model(input int s, input int d, input int maxh);
        int cur, h, dir, w;
        exp_pe.delete(); exp_dir.delete(); exp_rd.delete();
        exp_status = 0; exp_hops = 0;
        cur = s; h = 0;
        if (s == d) return;
        forever begin
            w = int'(mem[cur]);
            exp_rd.push_back(cur);
`ifdef TRACER_BYPASS_CHECK_EN
            if (cur != s && (w >> 4) > MAX_BYPASS) begin
                exp_status = 3; exp_hops = h; return;
            end
`endif
            if (cur % GRID < d % GRID)      dir = 3;
            else if (cur % GRID > d % GRID) dir = 2;
            else if (cur / GRID < d / GRID) dir = 0;
            else                            dir = 1;
            if (((w >> dir) & 1) == 0) begin
                exp_status = 1; exp_hops = h; return;
            end
            exp_pe.push_back(cur);
            exp_dir.push_back(dir);
            if (dir == 3)      cur = cur + 1;
            else if (dir == 2) cur = cur - 1;
            else if (dir == 0) cur = cur + GRID;
            else               cur = cur - GRID;
            h++;
            if (cur == d) begin exp_status = 0; exp_hops = h; return; end
            if (h == maxh) begin exp_status = 2; exp_hops = h; return; end
        end
    endtask

    // One complete walk on the main instance; 'stall' holds hop_ready low
    // for that many cycles on the first hop.
    task automatic walk(input int s, input int d, input int stall);
        int  n_hop, n_rd, left;
        bit  done;
        n_hop = 0; n_rd = 0; done = 0; left = stall;
        model(s, d, MAX_HOPS);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_src = PE_AW'(s); req_dst = PE_AW'(d); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (s == d) chk("same_pe_res_next_cycle", res_valid, 1);
        for (int c = 0; c < 300 && !done; c++) begin
            if (cfg_rd_en) begin
                if (n_rd < exp_rd.size()) chk("cfg_addr", cfg_addr, exp_rd[n_rd]);
                else chk("extra_cfg_read", n_rd, exp_rd.size());
                n_rd++;
            end
            if (hop_valid || res_valid) chk("hop_res_overlap", hop_valid & res_valid, 0);
            if (hop_valid) begin
                if (n_hop >= exp_pe.size()) begin
                    chk("extra_hop", n_hop, exp_pe.size());
                    hop_ready = 1'b1;
                    n_hop++;
                end else if (left > 0) begin
                    hop_ready = 1'b0;
                    left--;
                    chk("stall_hop_pe", hop_pe, exp_pe[n_hop]);
                    chk("stall_hop_dir", hop_dir, exp_dir[n_hop]);
                    chk("stall_no_read", cfg_rd_en, 0);
                end else begin
                    hop_ready = 1'b1;
                    chk("hop_pe", hop_pe, exp_pe[n_hop]);
                    chk("hop_dir", hop_dir, exp_dir[n_hop]);
                    n_hop++;
                end
            end
            if (res_valid) begin
                chk("res_status", res_status, exp_status);
                chk("res_hops", res_hops, exp_hops);
                done = 1;
            end
            @(negedge clk);
        end
        hop_ready = 1'b1;
        if (!done) chk("walk_timeout", 0, 1);
        chk("hop_count", n_hop, exp_pe.size());
        chk("cfg_read_count", n_rd, exp_rd.size());
    endtask

    initial begin
        int  n_hop;
        bit  done;
        for (int i = 0; i < GRID*GRID; i++) mem[i] = 6'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cfg_rd_en", cfg_rd_en, 0);
        chk("rst_hop_valid", hop_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cfg_addr", cfg_addr, 0);
        chk("rst_res_status", res_status, 0);
        chk("rst_res_hops", res_hops, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);

        // Straight path, broken path, same PE, backpressure
        mem[0] = 6'b001000; mem[1] = 6'b000001;
        walk(0, 5, 0);
        chk("straight_status_is_ok", exp_status, 0);
        walk(0, 5, 5);
        mem[1] = 6'b000000;
        walk(0, 5, 0);
        walk(7, 7, 0);

        // Bypass on the intermediate PE
        mem[0] = 6'b001000; mem[1] = 6'b111000; mem[2] = 6'b001000;
        walk(0, 3, 0);

        // Hop limit on the MAX_HOPS = 1 instance
        mem[1] = 6'b001000;
        model(0, 3, LIM_HOPS);
        @(negedge clk);
        chk("lim_req_ready", l_req_ready, 1);
        l_req_src = 4'd0; l_req_dst = 4'd3; l_req_valid = 1'b1;
        @(negedge clk);
        l_req_valid = 1'b0;
        n_hop = 0; done = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            if (l_hop_valid) n_hop++;
            if (l_res_valid) begin
                chk("lim_status", l_res_status, exp_status);
                chk("lim_hops", l_res_hops, exp_hops);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("lim_timeout", 0, 1);
        chk("lim_hop_count", n_hop, exp_pe.size());

        // Reset while a hop is pending
        mem[0] = 6'b001000; mem[1] = 6'b000001;
        @(negedge clk);
        req_src = 4'd0; req_dst = 4'd5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        hop_ready = 1'b0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (hop_valid) done = 1;
            else @(negedge clk);
        end
        if (!done) chk("reset_mid_wait_hop", 0, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_hop_valid", hop_valid, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_cfg_rd_en", cfg_rd_en, 0);
        chk("mid_rst_hop_pe", hop_pe, 0);
        chk("mid_rst_hop_dir", hop_dir, 0);
        chk("mid_rst_cfg_addr", cfg_addr, 0);
        reset = 1'b1;
        hop_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_ready", req_ready, 1);
        for (int c = 0; c < 5; c++) begin
            chk("no_stale_result", res_valid, 0);
            @(negedge clk);
        end

        // Randomised memories and endpoints
        for (int t = 0; t < 24; t++) begin
            int s, d, st;
            for (int i = 0; i < GRID*GRID; i++)
                mem[i] = 6'($urandom) | 6'($urandom) | 6'($urandom_range(0, 1) << 3);
            s  = $urandom_range(0, GRID*GRID-1);
            d  = $urandom_range(0, GRID*GRID-1);
            st = $urandom_range(0, 2);
            walk(s, d, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
